// File: rtl/vga_pixel_stream_pkg.sv
`default_nettype none
// ============================================================
// Package : vga_pixel_stream_pkg
// Shared VGA timing defaults, lock-state type and window helper.
// Rev     : 1.0
// ============================================================
package vga_pixel_stream_pkg;

  localparam int unsigned DEF_H_BACK_PORCH = 48;
  localparam int unsigned DEF_H_ACTIVE     = 640;
  localparam int unsigned DEF_V_BACK_PORCH = 33;
  localparam int unsigned DEF_V_ACTIVE     = 480;
  localparam int unsigned DEF_CNT_W        = 10;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Evaluated at 32 bits so a saturated counter can never alias into the window
  function automatic logic in_window(input logic [31:0] val,
                                     input logic [31:0] lo,
                                     input logic [31:0] len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_stream_if.sv
`default_nettype none
// ============================================================
// Interface : vga_pixel_stream_if
// Sync-in / coordinate-out / colour-in / RGB-out bundle.
// Rev       : 1.0
// ============================================================
interface vga_pixel_stream_if #(
  parameter int unsigned CNT_W = 10
);
  logic             clk_pixel;
  logic             hsync;
  logic             vsync;
  logic [7:0]       color_in;
  logic [CNT_W-1:0] px_x;
  logic [CNT_W-1:0] px_y;
  logic             px_active;
  logic             frame_start;
  logic [2:0]       red;
  logic [2:0]       green;
  logic [1:0]       blue;
  logic             hsync_out;
  logic             vsync_out;
  logic             locked;

  modport master (
    input  clk_pixel, hsync, vsync, color_in,
    output px_x, px_y, px_active, frame_start, red, green, blue,
           hsync_out, vsync_out, locked
  );

  modport slave (
    output clk_pixel, hsync, vsync, color_in,
    input  px_x, px_y, px_active, frame_start, red, green, blue,
           hsync_out, vsync_out, locked
  );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_stream_sync_edge.sv
`default_nettype none
// ============================================================
// Module : vga_sync_edge
// Enable-qualified rising-edge detector; prev resets high.
// Rev    : 1.0
// ============================================================
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync,
  output logic rise,
  output logic prev
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else if (en) begin
      r_prev <= sync;
    end
  end

  assign rise = en & sync & ~r_prev;
  assign prev = r_prev;

endmodule
`default_nettype wire

// File: rtl/vga_pixel_stream.sv
`default_nettype none
// ============================================================
// Module : vga_pixel_stream
// Recovers pixel coordinates from sync, blanks and aligns RGB.
// Rev    : 1.0
// ============================================================
module vga_pixel_stream
  import vga_pixel_stream_pkg::*;
#(
  parameter int unsigned H_BACK_PORCH = DEF_H_BACK_PORCH,
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned V_BACK_PORCH = DEF_V_BACK_PORCH,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst,
  vga_pixel_stream_if.master bus
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_HBP     = CNT_W'(H_BACK_PORCH);
  localparam logic [CNT_W-1:0] C_VBP     = CNT_W'(V_BACK_PORCH);

  logic             w_hs_rise, w_hs_prev, w_vs_rise, w_vs_prev;
  logic [CNT_W-1:0] r_h_cnt, r_v_cnt, w_h_nxt, w_v_nxt, w_x_nxt, w_y_nxt;
  lock_state_t      r_state, w_state_nxt;
  logic             w_act_nxt;
  logic             r_px_active, r_frame_start, r_hsync_out, r_vsync_out;
  logic [CNT_W-1:0] r_px_x, r_px_y;
  logic [7:0]       r_rgb;

  vga_sync_edge u_hs_edge (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.clk_pixel),
    .sync (bus.hsync),
    .rise (w_hs_rise),
    .prev (w_hs_prev)
  );

  vga_sync_edge u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.clk_pixel),
    .sync (bus.vsync),
    .rise (w_vs_rise),
    .prev (w_vs_prev)
  );

  always_comb begin
    w_h_nxt = w_hs_rise ? '0 : ((r_h_cnt == C_CNT_MAX) ? r_h_cnt : r_h_cnt + C_ONE);
    w_v_nxt = r_v_cnt;
    if (w_vs_rise) begin
      w_v_nxt = '0;
    end else if (w_hs_rise && (r_v_cnt != C_CNT_MAX)) begin
      w_v_nxt = r_v_cnt + C_ONE;
    end

    // A saturated counter means the sync stream has been lost
    w_state_nxt = r_state;
    case (r_state)
      UNLOCKED: if (w_vs_rise) w_state_nxt = LOCKED;
      LOCKED:   if ((w_h_nxt == C_CNT_MAX) || (w_v_nxt == C_CNT_MAX)) w_state_nxt = UNLOCKED;
      default:  w_state_nxt = UNLOCKED;
    endcase

    w_act_nxt = (w_state_nxt == LOCKED)
              && in_window(32'(w_h_nxt), H_BACK_PORCH, H_ACTIVE)
              && in_window(32'(w_v_nxt), V_BACK_PORCH, V_ACTIVE);
    w_x_nxt   = w_act_nxt ? (w_h_nxt - C_HBP) : '0;
    w_y_nxt   = w_act_nxt ? (w_v_nxt - C_VBP) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_state       <= UNLOCKED;
      r_px_active   <= 1'b0;
      r_px_x        <= '0;
      r_px_y        <= '0;
      r_frame_start <= 1'b0;
      r_rgb         <= 8'h00;
      r_hsync_out   <= 1'b1;
      r_vsync_out   <= 1'b1;
    end else if (bus.clk_pixel) begin
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_state       <= w_state_nxt;
      r_px_active   <= w_act_nxt;
      r_px_x        <= w_x_nxt;
      r_px_y        <= w_y_nxt;
      r_frame_start <= w_act_nxt && (w_x_nxt == '0) && (w_y_nxt == '0);
      r_rgb         <= r_px_active ? bus.color_in : 8'h00;
      // prev already holds sync from one enable back; one more stage aligns with colour
      r_hsync_out   <= w_hs_prev;
      r_vsync_out   <= w_vs_prev;
    end else begin
      r_frame_start <= 1'b0;
    end
  end

  assign bus.px_x        = r_px_x;
  assign bus.px_y        = r_px_y;
  assign bus.px_active   = r_px_active;
  assign bus.frame_start = r_frame_start;
  assign bus.red         = r_rgb[7:5];
  assign bus.green       = r_rgb[4:2];
  assign bus.blue        = r_rgb[1:0];
  assign bus.hsync_out   = r_hsync_out;
  assign bus.vsync_out   = r_vsync_out;
  assign bus.locked      = (r_state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_stream.sv
`default_nettype none
// ============================================================
// Module : tb_vga_pixel_stream
// Directed 800-enable-line sync stream with a per-enable reference model.
// Rev    : 1.0
// ============================================================
module tb_vga_pixel_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_pixel_stream_if #(.CNT_W(10)) bus ();

  vga_pixel_stream dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int line_bad, act_cnt, fs_cnt, first_h, last_x;
  bit cmode;

  // Expected values of what the DUT currently shows
  logic       m_act, m_hs, m_vs;
  int         m_x, m_y;
  logic [7:0] m_rgb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_x = 0; m_y = 0; m_hs = 1'b1; m_vs = 1'b1; m_rgb = 8'h00;
  endtask

  // One pixel enable; h/v are the counter values the sync pattern implies
  task automatic step(input logic hs, input logic vs, input bit lk, input int h, input int v);
    logic [7:0] col, e_rgb;
    logic       e_act, e_fs;
    int         e_x, e_y;
    col = cmode ? 8'(m_x * 3 + m_y + 17) : 8'hE3;
    bus.clk_pixel = 1'b1;
    bus.hsync     = hs;
    bus.vsync     = vs;
    bus.color_in  = col;
    @(posedge clk); #1;
    e_act = lk && (h >= 48) && (h < 688) && (v >= 33) && (v < 513);
    e_x   = e_act ? h - 48 : 0;
    e_y   = e_act ? v - 33 : 0;
    e_fs  = e_act && (e_x == 0) && (e_y == 0);
    e_rgb = m_act ? col : 8'h00;
    if (bus.px_active !== e_act || bus.px_x !== 10'(e_x) || bus.px_y !== 10'(e_y)
        || bus.frame_start !== e_fs || {bus.red, bus.green, bus.blue} !== e_rgb
        || bus.hsync_out !== m_hs || bus.vsync_out !== m_vs || bus.locked !== lk)
      line_bad++;
    if (bus.px_active === 1'b1) begin
      if (act_cnt == 0) first_h = h;
      act_cnt++;
      last_x = int'(bus.px_x);
    end
    if (bus.frame_start === 1'b1) fs_cnt++;
    m_act = e_act; m_x = e_x; m_y = e_y; m_hs = hs; m_vs = vs; m_rgb = e_rgb;
  endtask

  task automatic run_line(input logic vs, input bit lk, input int v, input int from, input int to);
    for (int i = from; i <= to; i++) step(i < 704, vs, lk, i, v);
  endtask

  task automatic idle();
    bus.clk_pixel = 1'b0;
    @(posedge clk); #1;
    check("gate_frame_start", 32'(bus.frame_start), 0);
    check("gate_hold",
          32'({bus.px_active, bus.px_x, bus.px_y, bus.red, bus.green, bus.blue, bus.hsync_out}),
          32'({m_act, 10'(m_x), 10'(m_y), m_rgb, m_hs}));
  endtask

  initial begin
    rst = 1'b1;
    bus.clk_pixel = 1'b1; bus.hsync = 1'b1; bus.vsync = 1'b1; bus.color_in = 8'h00;
    cmode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_px_x",        32'(bus.px_x), 0);
    check("rst_px_y",        32'(bus.px_y), 0);
    check("rst_px_active",   32'(bus.px_active), 0);
    check("rst_frame_start", 32'(bus.frame_start), 0);
    check("rst_rgb",         32'({bus.red, bus.green, bus.blue}), 0);
    check("rst_hsync_out",   32'(bus.hsync_out), 1);
    check("rst_vsync_out",   32'(bus.vsync_out), 1);
    check("rst_locked",      32'(bus.locked), 0);
    rst = 1'b0;

    // Two lines with vsync low: nothing may lock or go active
    line_bad = 0; act_cnt = 0; fs_cnt = 0;
    run_line(1'b0, 1'b0, 0, 0, 799);
    run_line(1'b0, 1'b0, 0, 0, 799);
    check("prelock_map",    32'(line_bad), 0);
    check("prelock_active", 32'(act_cnt), 0);
    check("prelock_locked", 32'(bus.locked), 0);

    // hsync and vsync rise on the same enable: lock, both counters to 0
    step(1'b1, 1'b1, 1'b1, 0, 0);
    check("lock_on_vsync_rise", 32'(bus.locked), 1);
    run_line(1'b1, 1'b1, 0, 1, 799);
    for (int ln = 1; ln < 33; ln++) run_line(1'b1, 1'b1, ln, 0, 799);
    check("lines_0_32_map",  32'(line_bad), 0);
    check("lines_0_32_act",  32'(act_cnt), 0);
    check("lines_0_32_fs",   32'(fs_cnt), 0);

    // First active line, with pixel-enable gaps inserted
    act_cnt = 0; fs_cnt = 0;
    run_line(1'b1, 1'b1, 33, 0, 48);
    check("fs_line33",   32'(bus.frame_start), 1);
    check("fs_px_x",     32'(bus.px_x), 0);
    check("fs_px_y",     32'(bus.px_y), 0);
    idle();
    run_line(1'b1, 1'b1, 33, 49, 100);
    idle();
    run_line(1'b1, 1'b1, 33, 101, 799);
    check("line33_map",     32'(line_bad), 0);
    check("line33_first_h", 32'(first_h), 48);
    check("line33_count",   32'(act_cnt), 640);
    check("line33_last_x",  32'(last_x), 639);
    check("line33_fs_once", 32'(fs_cnt), 1);

    // Coordinate-dependent colour exposes any coordinate/colour misalignment
    cmode = 1'b1; act_cnt = 0; fs_cnt = 0;
    run_line(1'b1, 1'b1, 34, 0, 799);
    check("line34_map",   32'(line_bad), 0);
    check("line34_no_fs", 32'(fs_cnt), 0);
    check("line34_count", 32'(act_cnt), 640);

    // Reset in the middle of an active line
    run_line(1'b1, 1'b1, 35, 0, 300);
    check("pre_rst_active", 32'(bus.px_active), 1);
    rst = 1'b1; bus.clk_pixel = 1'b1;
    @(posedge clk); #1;
    check("midrst_active", 32'(bus.px_active), 0);
    check("midrst_rgb",    32'({bus.red, bus.green, bus.blue}), 0);
    check("midrst_locked", 32'(bus.locked), 0);
    check("midrst_px_x",   32'(bus.px_x), 0);
    check("midrst_hs_out", 32'(bus.hsync_out), 1);
    rst = 1'b0;
    model_reset();
    act_cnt = 0;
    run_line(1'b1, 1'b0, 35, 301, 799);
    run_line(1'b0, 1'b0, 0, 0, 799);
    check("post_rst_map",    32'(line_bad), 0);
    check("post_rst_active", 32'(act_cnt), 0);

    // Relock, then hold hsync low until h_cnt saturates
    for (int i = 0; i < 1804; i++) begin
      step(i < 704, 1'b1, i < 1023, (i < 1023) ? i : 1023, 0);
      if (i == 1022) check("locked_before_sat", 32'(bus.locked), 1);
      if (i == 1023) check("unlock_at_sat", 32'(bus.locked), 0);
    end
    check("sat_map", 32'(line_bad), 0);
    check("sat_rgb", 32'({bus.red, bus.green, bus.blue}), 0);

    // Next vsync rise relocks
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1023, 0);
    step(1'b1, 1'b1, 1'b1, 0, 0);
    check("relock", 32'(bus.locked), 1);
    for (int i = 1; i <= 50; i++) step(1'b1, 1'b1, 1'b1, i, 0);
    check("relock_map", 32'(line_bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
